// File: rtl/arith_seq_pkg.sv
// Shared encodings for the arithmetic sequencer: FSM states, forced ALU op,
// PC step and the datapath operand-select constants.
package arith_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_INCR  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [2:0]  ALU_ADD = 3'b010;
  localparam logic [31:0] PC_STEP = 32'd4;

  localparam logic A_RS   = 1'b0;
  localparam logic A_PC   = 1'b1;
  localparam logic B_DEC  = 1'b0;
  localparam logic B_FOUR = 1'b1;

endpackage

// File: rtl/seq_retire_counter.sv
// Free-running CW-bit retired-instruction counter; wraps silently at all-ones.
// Single-cycle increment when inc_i is high, async active-high clear.
module seq_retire_counter #(
  parameter int CW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/arith_sequencer.sv
// FETCH/EXEC/INCR controller sharing one ALU between the register op and PC+4.
// Retired counter present only when ARITH_SEQ_RETIRE_CNT_EN is defined.
module arith_sequencer
  import arith_seq_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inst_ready,
  input  logic          except,
  input  logic          dec_write,
  output logic          ir_en,
  output logic          pc_en,
  output logic          alu_a_sel,
  output logic          alu_b_sel,
  output logic          alu_op_force,
  output logic          rf_wr_en,
  output logic          halted,
  output logic [1:0]    state,
  output logic [CW-1:0] retired
);

  state_e state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: if (inst_ready) state_q <= ST_EXEC;
        ST_EXEC:  state_q <= except ? ST_HALT : ST_INCR;
        ST_INCR:  state_q <= ST_FETCH;
        default:  state_q <= ST_HALT;
      endcase
    end
  end

  // Outputs are combinational so the enables drop the instant reset rises.
  always_comb begin
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    alu_a_sel    = A_RS;
    alu_b_sel    = B_DEC;
    alu_op_force = 1'b0;
    rf_wr_en     = 1'b0;
    halted       = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: ir_en = inst_ready;
        ST_EXEC:  rf_wr_en = dec_write & ~except;
        ST_INCR: begin
          alu_a_sel    = A_PC;
          alu_b_sel    = B_FOUR;
          alu_op_force = 1'b1;
          pc_en        = 1'b1;
        end
        default:  halted = 1'b1;
      endcase
    end
  end

  assign state = state_q;

`ifdef ARITH_SEQ_RETIRE_CNT_EN
  seq_retire_counter #(.CW(CW)) u_retire_cnt (
    .clk_i   (clock),
    .rst_i   (reset),
    .inc_i   (state_q == ST_INCR),
    .count_o (retired)
  );
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_arith_sequencer.sv
// Bench for arith_sequencer (CW=4): directed scenarios plus randomized traffic
// compared every cycle against an instruction-level reference model.
module tb_arith_sequencer;

  localparam int TCW = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           inst_ready, except, dec_write;
  logic           ir_en, pc_en, alu_a_sel, alu_b_sel, alu_op_force, rf_wr_en, halted;
  logic [1:0]     state;
  logic [TCW-1:0] retired;

  int checks = 0;
  int errors = 0;

  arith_sequencer #(.CW(TCW)) dut (
    .clock        (clock),
    .reset        (reset),
    .inst_ready   (inst_ready),
    .except       (except),
    .dec_write    (dec_write),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op_force (alu_op_force),
    .rf_wr_en     (rf_wr_en),
    .halted       (halted),
    .state        (state),
    .retired      (retired)
  );

  always #5 clock = ~clock;

`ifdef ARITH_SEQ_RETIRE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ret_exp(input int n);
    return CNT_ON ? 32'(n % (1 << TCW)) : 32'd0;
  endfunction

  // Reference model: where we are within the current instruction, whether the
  // machine has died, and how many instructions have completed.
  int m_step;     // 0 = waiting for instruction, 1 = executing, 2 = advancing PC
  bit m_dead;
  int m_done;
  bit cmp_en = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_step = 0;
      m_dead = 1'b0;
      m_done = 0;
    end else if (!m_dead) begin
      if (m_step == 0) begin
        if (inst_ready) m_step = 1;
      end else if (m_step == 1) begin
        if (except) m_dead = 1'b1;
        else m_step = 2;
      end else begin
        m_step = 0;
        m_done = m_done + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      logic in_fetch, in_exec, in_incr, live;
      live     = !reset && !m_dead;
      in_fetch = live && m_step == 0;
      in_exec  = live && m_step == 1;
      in_incr  = live && m_step == 2;
      chk("m_state",   32'(state),        (reset || !m_dead) ? 32'(reset ? 0 : m_step) : 32'd3);
      chk("m_ir_en",   32'(ir_en),        32'(in_fetch && inst_ready));
      chk("m_rf_wr",   32'(rf_wr_en),     32'(in_exec && dec_write && !except));
      chk("m_pc_en",   32'(pc_en),        32'(in_incr));
      chk("m_a_sel",   32'(alu_a_sel),    32'(in_incr));
      chk("m_b_sel",   32'(alu_b_sel),    32'(in_incr));
      chk("m_force",   32'(alu_op_force), 32'(in_incr));
      chk("m_halted",  32'(halted),       32'(!reset && m_dead));
      chk("m_retired", 32'(retired),      ret_exp(m_done));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_st [9];
    bit found;
    exp_st = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    reset = 1'b1; inst_ready = 1'b0; except = 1'b0; dec_write = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    cmp_en = 1'b1;

    // Three back-to-back instructions, writing every time.
    reset = 1'b0; inst_ready = 1'b1; dec_write = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      chk("seq_state", 32'(state), 32'(exp_st[c-1]));
      chk("seq_rf_wr", 32'(rf_wr_en), 32'(c == 2 || c == 5 || c == 8));
      chk("seq_pc_en", 32'(pc_en), 32'(c == 3 || c == 6 || c == 9));
    end
    @(posedge clock); #1;
    inst_ready = 1'b0;
    @(negedge clock);
    chk("seq_retired3", 32'(retired), ret_exp(3));

    // Instruction memory stalls four cycles.
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clock);
      chk("stall_state", 32'(state), 32'd0);
      chk("stall_ir_en", 32'(ir_en), 32'd0);
    end
    @(posedge clock); #1;
    inst_ready = 1'b1;
    @(negedge clock);
    chk("ready_ir_en", 32'(ir_en), 32'd1);
    @(posedge clock); #1;
    inst_ready = 1'b0; except = 1'b1; dec_write = 1'b1;
    @(negedge clock);
    chk("exc_state", 32'(state), 32'd1);
    chk("exc_rf_wr", 32'(rf_wr_en), 32'd0);
    chk("exc_pc_en", 32'(pc_en), 32'd0);
    @(posedge clock); #1;
    for (int c = 0; c < 20; c++) begin
      inst_ready = 1'($urandom); except = 1'($urandom); dec_write = 1'($urandom);
      @(negedge clock);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_pc_en", 32'(pc_en), 32'd0);
      chk("halt_retired", 32'(retired), ret_exp(3));
      @(posedge clock); #1;
    end

    // Asynchronous reset landing in the middle of an INCR cycle.
    reset = 1'b1; except = 1'b0; dec_write = 1'b0; inst_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clock); #1;
      if (state == 2'd2) found = 1'b1;
    end
    chk("incr_reached", 32'(found), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pc_en", 32'(pc_en), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_retired", 32'(retired), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("resume_fetch", 32'(state), 32'd0);
    @(negedge clock);
    chk("resume_exec", 32'(state), 32'd1);

    // Seventeen instructions through a 4-bit counter.
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; inst_ready = 1'b1; except = 1'b0; dec_write = 1'b0;
    repeat (45) @(posedge clock);
    @(negedge clock);
    chk("wrap_15", 32'(retired), CNT_ON ? 32'd15 : 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("wrap_0", 32'(retired), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("wrap_1", 32'(retired), CNT_ON ? 32'd1 : 32'd0);

    // Randomized traffic; occasional reset revives the machine after a halt.
    @(posedge clock); #1;
    for (int c = 0; c < 600; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      except     = ($urandom_range(0, 15) == 0);
      dec_write  = 1'($urandom);
      reset      = ($urandom_range(0, 39) == 0);
      if (c % 7 == 3) begin
        #3;
        reset = ($urandom_range(0, 9) == 0);
      end
      @(posedge clock); #1;
    end
    reset = 1'b0;
    @(negedge clock);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_sequencer.md
# arith_sequencer

Multi-cycle controller that sequences the single-ALU arithmetic datapath. It steps each instruction through fetch, execute and PC-increment, sharing one `alu32` between the register operation and the PC+4 update. It gates the register-file write and the PC enable, and halts permanently on an unrecognized instruction. It sits beside `mips_decode` and drives the datapath's mux selects and enables in place of a dedicated PC adder.

## Interface
- `CW`, 32, width of the retired-instruction counter
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; returns the block to FETCH
- `inst_ready`  in  1  instruction memory output valid this cycle
- `except`  in  1  unrecognized-instruction flag from `mips_decode`
- `dec_write`  in  1  register-write request from `mips_decode`
- `ir_en`  out  1  load the instruction register
- `pc_en`  out  1  PC register enable
- `alu_a_sel`  out  1  0 = rsData, 1 = PC
- `alu_b_sel`  out  1  0 = decoder B path (rtData/imm32), 1 = constant 4
- `alu_op_force`  out  1  0 = decoder alu_op, 1 = forced add (3'b010)
- `rf_wr_en`  out  1  register-file write enable
- `halted`  out  1  high in HALT
- `state`  out  2  current state, for debug
- `retired`  out  CW  count of completed instructions

## Operation
- States and encodings: FETCH = 0, EXEC = 1, INCR = 2, HALT = 3.
- **FETCH**
  - `ir_en = inst_ready`.
  - If `inst_ready` is high, go to EXEC. Otherwise stay.
- **EXEC**
  - ALU computes rs op B using the decoder's alu_op. Selects = 0.
  - If `except` is high, go to HALT with `rf_wr_en = 0`. The PC is not updated.
  - Otherwise `rf_wr_en = dec_write`, then go to INCR.
- **INCR**
  - `alu_a_sel = 1`, `alu_b_sel = 1`, `alu_op_force = 1`, `pc_en = 1`.
  - `retired` increments by 1.
  - Go to FETCH unconditionally.
- **HALT**
  - All enables are 0. `halted = 1`.
  - Leaves only on reset. `inst_ready`, `except` and `dec_write` are ignored.
- All outputs not listed for a state are 0.
- All outputs are combinational from `state`, plus `inst_ready` in FETCH and `except`/`dec_write` in EXEC.
- `except` and `dec_write` both high in EXEC: the write is suppressed and the block halts.
- `except` is ignored outside EXEC.
- `retired` is modulo 2^CW: all-ones wraps to 0 with no flag.

## Timing
- Minimum 3 cycles per instruction: FETCH with `inst_ready` high, EXEC, INCR.
- Each cycle `inst_ready` is low in FETCH adds one cycle.
- The register-file write commits on the clock edge ending EXEC.
- The PC and `retired` update on the clock edge ending INCR.
- HALT is entered on the edge ending the EXEC in which `except` was sampled high. `halted` rises in the following cycle.
- **Reset asserted (any time, including mid-EXEC or mid-INCR)**
  - Takes effect immediately, with no clock edge needed.
  - `state` = FETCH, `retired` = 0, `halted` = 0.
  - `ir_en`, `pc_en`, `rf_wr_en`, all selects and `alu_op_force` are forced to 0 while reset is high.
  - A write or PC update in progress is abandoned.
- **Reset deasserted:** FETCH is evaluated on the next rising edge.

## Configuration
- Macro: `ARITH_SEQ_RETIRE_CNT_EN`.
- Defined: the CW-bit retired counter is implemented as described above.
- Undefined: no counter flops. `retired` is tied to 0. State behaviour is unchanged.

## Structure
- Package `arith_seq_pkg` holds:
  - state encodings (`ST_FETCH`, `ST_EXEC`, `ST_INCR`, `ST_HALT`)
  - `ALU_ADD = 3'b010`
  - `PC_STEP = 32'd4`
  - select constants (`A_RS`, `A_PC`, `B_DEC`, `B_FOUR`)
- One sub-module, `seq_retire_counter`: parameterized CW-bit counter with async reset and an increment enable. It is instantiated only under `ARITH_SEQ_RETIRE_CNT_EN`.

## Test plan
- Reset then release, `inst_ready = 1`, `except = 0`, `dec_write = 1` for 3 instructions:
  - `state` sequence is 0,1,2,0,1,2,0,1,2.
  - `rf_wr_en` is high only in cycles 2, 5, 8. `pc_en` is high only in cycles 3, 6, 9.
  - `retired` = 3.
- `inst_ready` held low 4 cycles in FETCH: `state` stays 0 and `ir_en` stays 0. On the cycle `inst_ready` goes high, `ir_en = 1` and the next state is EXEC.
- `except = 1` and `dec_write = 1` in EXEC:
  - `rf_wr_en = 0`, and `pc_en` never pulses.
  - `halted = 1` next cycle and stays high for 20 cycles regardless of inputs.
  - `retired` is unchanged.
- Reset asserted asynchronously mid-INCR (between clock edges):
  - `pc_en` drops immediately, and `state` = 0, `retired` = 0 before the next edge.
  - After release, normal fetch resumes.
- With CW = 4 and the macro defined, run 17 instructions: `retired` goes 15→0→1. With the macro undefined, `retired` stays 0 throughout.
